// File: rtl/micro_sequencer.sv
// micro_sequencer: control-store address sequencer.
// Registers the next microinstruction address each cycle from the COND and
// JUMP_ADDR fields, the PSR flags and the instruction register, and stalls the
// microprogram while a memory access is outstanding.
module micro_sequencer #(
  parameter int JUMP_ADDR_BUS_WIDTH = 11,
  parameter int COND_BUS_WIDTH      = 3,
  parameter int IR_BUS_WIDTH        = 32
) (
  input  logic                           uSEQ_CLOCK_50,
  input  logic                           uSEQ_RESET_InLow,
  input  logic [COND_BUS_WIDTH-1:0]      uSEQ_COND_IN,
  input  logic [JUMP_ADDR_BUS_WIDTH-1:0] uSEQ_JUMP_ADDR_IN,
  input  logic                           uSEQ_RD_IN,
  input  logic                           uSEQ_WR_IN,
  input  logic                           uSEQ_MEM_DONE_IN,
  input  logic [IR_BUS_WIDTH-1:0]        uSEQ_IR_IN,
  input  logic [3:0]                     uSEQ_FLAGS_IN,
  output logic [JUMP_ADDR_BUS_WIDTH-1:0] uSEQ_CS_ADDR_OUT,
  output logic                           uSEQ_STALL_OUT,
  output logic                           uSEQ_BRANCH_TAKEN_OUT
);

  typedef enum logic [1:0] {
    PRIME    = 2'd0,
    RUN      = 2'd1,
    WAIT_MEM = 2'd2
  } state_t;

  state_t                         state, state_next;
  logic [JUMP_ADDR_BUS_WIDTH-1:0] upc, upc_next;
  logic                           taken, taken_next;

  logic [JUMP_ADDR_BUS_WIDTH-1:0] seq_addr;
  logic [JUMP_ADDR_BUS_WIDTH-1:0] decode_addr;
  logic [JUMP_ADDR_BUS_WIDTH-1:0] target_addr;
  logic                           target_taken;
  logic                           mem_req;

  // Only a handful of IR bits steer the sequencer; fold the rest away.
  logic unused_ir;
  assign unused_ir = ^uSEQ_IR_IN;

  assign seq_addr    = upc + JUMP_ADDR_BUS_WIDTH'(1);
  assign decode_addr = JUMP_ADDR_BUS_WIDTH'({1'b1, uSEQ_IR_IN[31:30], uSEQ_IR_IN[24:19], 2'b00});
  assign mem_req     = uSEQ_RD_IN | uSEQ_WR_IN;

  // Branch resolution: pick the candidate address and note whether it is a transfer.
  always_comb begin
    target_addr  = seq_addr;
    target_taken = 1'b0;
    case (uSEQ_COND_IN)
      3'd1: target_taken = uSEQ_FLAGS_IN[3];
      3'd2: target_taken = uSEQ_FLAGS_IN[2];
      3'd3: target_taken = uSEQ_FLAGS_IN[1];
      3'd4: target_taken = uSEQ_FLAGS_IN[0];
      3'd5: target_taken = uSEQ_IR_IN[13];
      3'd6: target_taken = 1'b1;
      default: target_taken = 1'b0;
    endcase
    if (target_taken) begin
      target_addr = uSEQ_JUMP_ADDR_IN;
    end
    // Decode dispatch always counts as a transfer, even if it lands on uPC+1.
    if (uSEQ_COND_IN == 3'd7) begin
      target_addr  = decode_addr;
      target_taken = 1'b1;
    end
  end

  // Next-state and next-address logic; holding cycles never report a branch.
  always_comb begin
    state_next = state;
    upc_next   = upc;
    taken_next = 1'b0;
    case (state)
      PRIME: begin
        upc_next   = '0;
        state_next = RUN;
      end
      RUN: begin
        if (mem_req && !uSEQ_MEM_DONE_IN) begin
          state_next = WAIT_MEM;
        end else begin
          upc_next   = target_addr;
          taken_next = target_taken;
        end
      end
      WAIT_MEM: begin
        if (uSEQ_MEM_DONE_IN) begin
          upc_next   = target_addr;
          taken_next = target_taken;
          state_next = RUN;
        end
      end
      default: begin
        upc_next   = '0;
        state_next = PRIME;
      end
    endcase
  end

  // State, micro-PC and branch flag registers; reset clears all at once.
  always_ff @(posedge uSEQ_CLOCK_50 or negedge uSEQ_RESET_InLow) begin
    if (!uSEQ_RESET_InLow) begin
      state <= PRIME;
      upc   <= '0;
      taken <= 1'b0;
    end else begin
      state <= state_next;
      upc   <= upc_next;
      taken <= taken_next;
    end
  end

  assign uSEQ_CS_ADDR_OUT      = upc;
  assign uSEQ_STALL_OUT        = (state == WAIT_MEM);
  assign uSEQ_BRANCH_TAKEN_OUT = taken;

endmodule
